// File: rtl/motor_pwm_bank_pkg.sv
// rtl/motor_pwm_bank_pkg.sv - register map and GPIO nibble layout for motor_pwm_bank
package motor_pwm_bank_pkg;

  localparam logic [4:0] CTRL_BASE   = 5'd0;
  localparam logic [4:0] DUTY_BASE   = 5'd8;
  localparam logic [4:0] STATUS_ADDR = 5'd16;
  localparam logic [4:0] KICK_ADDR   = 5'd17;
  localparam logic [4:0] EFF_BASE    = 5'd24;

  localparam int CTRL_EN_BIT  = 0;
  localparam int CTRL_DIR_BIT = 1;

  // Field order gives GPIO nibble bits {3:pwm, 2:en, 1:in2, 0:in1}.
  typedef struct packed {
    logic pwm;
    logic en;
    logic in2;
    logic in1;
  } gpio_nibble_t;

endpackage

// File: rtl/motor_pwm_bank_pwm_channel.sv
// rtl/motor_pwm_bank_pwm_channel.sv - one H-bridge channel: slew-limited duty, reversal interlock, output decode
module motor_pwm_bank_pwm_channel
  import motor_pwm_bank_pkg::*;
#(
  parameter int DUTY_W    = 10,
  parameter int RAMP_STEP = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DUTY_W-1:0] cnt_i,
  input  logic              wrap_i,
  input  logic [DUTY_W-1:0] target_i,
  input  logic              en_i,
  input  logic              dir_i,
  input  logic              force_off_i,
  output logic [DUTY_W-1:0] eff_o,
  output gpio_nibble_t      gpio_o
);

  localparam logic [DUTY_W:0] STEP = (DUTY_W+1)'(RAMP_STEP);

  logic [DUTY_W-1:0] eff_q, eff_d;
  logic              dir_q, dir_d;
  logic [DUTY_W:0]   eff_x, tgt_x;
  logic              active;
  logic              pwm;

  assign active = en_i & ~force_off_i;

  always_comb begin
    eff_d = eff_q;
    dir_d = dir_q;
    eff_x = {1'b0, eff_q};
    tgt_x = {1'b0, target_i};
    if (!active) begin
      eff_d = '0;
    end else if (wrap_i) begin
      // Reversal: drain to zero first; the flip and the first ramp-up step share one wrap.
      if (dir_q != dir_i && eff_q != '0) begin
        eff_d = (eff_x > STEP) ? DUTY_W'(eff_x - STEP) : '0;
      end else begin
        dir_d = dir_i;
        if (tgt_x > eff_x + STEP)      eff_d = DUTY_W'(eff_x + STEP);
        else if (eff_x > tgt_x + STEP) eff_d = DUTY_W'(eff_x - STEP);
        else                           eff_d = target_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      eff_q <= '0;
      dir_q <= 1'b0;
    end else begin
      eff_q <= eff_d;
      dir_q <= dir_d;
    end
  end

  assign pwm        = active & (cnt_i < eff_q);
  assign eff_o      = eff_q;
  assign gpio_o.pwm = pwm;
  assign gpio_o.en  = active;
  assign gpio_o.in1 = pwm & ~dir_q;
  assign gpio_o.in2 = pwm & dir_q;

endmodule

// File: rtl/motor_pwm_bank.sv
// rtl/motor_pwm_bank.sv - Avalon-MM motor PWM bank: register file, read mux, shared PWM counter, bus watchdog
module motor_pwm_bank
  import motor_pwm_bank_pkg::*;
#(
  parameter int NUM_MOTORS  = 6,
  parameter int DUTY_W      = 10,
  parameter int RAMP_STEP   = 4,
  parameter int WDOG_CYCLES = 50_000_000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    chipselect,
  input  logic                    write,
  input  logic                    read,
  input  logic [4:0]              addr,
  input  logic [31:0]             writedata,
  output logic [31:0]             readdata,
  output logic [4*NUM_MOTORS-1:0] GPIO_out
);

  localparam int WD_W = $clog2(WDOG_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_CYCLES - 1);
  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(WDOG_CYCLES);

  logic [DUTY_W-1:0]     cnt_q;
  logic [NUM_MOTORS-1:0] en_q, dir_q;
  logic [DUTY_W-1:0]     duty_q [NUM_MOTORS];
  logic [DUTY_W-1:0]     eff    [NUM_MOTORS];
  logic [WD_W-1:0]       wd_cnt_q;
  logic                  wd_trip_q;
  logic [31:0]           readdata_q, readdata_d;
  logic                  wr, wrap, is_ctrl, is_duty, is_eff;
  logic [2:0]            idx;
  logic                  unused_wdata;

  assign wr           = chipselect & write;
  assign wrap         = &cnt_q;
  assign idx          = addr[2:0];
  assign is_ctrl      = (addr[4:3] == CTRL_BASE[4:3]);
  assign is_duty      = (addr[4:3] == DUTY_BASE[4:3]);
  assign is_eff       = (addr[4:3] == EFF_BASE[4:3]);
  assign unused_wdata = ^writedata[31:DUTY_W];

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= '0;
      wd_cnt_q   <= '0;
      wd_trip_q  <= 1'b0;
      en_q       <= '0;
      dir_q      <= '0;
      readdata_q <= '0;
      for (int i = 0; i < NUM_MOTORS; i++) duty_q[i] <= '0;
    end else begin
      cnt_q <= cnt_q + DUTY_W'(1);

      // A write in the expiry cycle reloads the counter and suppresses the trip.
      if (wr)                      wd_cnt_q <= '0;
      else if (wd_cnt_q != WD_MAX) wd_cnt_q <= wd_cnt_q + WD_W'(1);
      if (wr && addr == KICK_ADDR)         wd_trip_q <= 1'b0;
      else if (!wr && wd_cnt_q == WD_LAST) wd_trip_q <= 1'b1;

      for (int i = 0; i < NUM_MOTORS; i++) begin
        if (wd_trip_q) begin
          en_q[i]   <= 1'b0;
          duty_q[i] <= '0;
        end else if (wr && idx == 3'(i)) begin
          if (is_ctrl) begin
            en_q[i]  <= writedata[CTRL_EN_BIT];
            dir_q[i] <= writedata[CTRL_DIR_BIT];
          end
          if (is_duty) duty_q[i] <= writedata[DUTY_W-1:0];
        end
      end

      if (chipselect && read) readdata_q <= readdata_d;
    end
  end

  always_comb begin
    readdata_d = '0;
    for (int i = 0; i < NUM_MOTORS; i++) begin
      if (idx == 3'(i)) begin
        if (is_ctrl) begin
          readdata_d[CTRL_EN_BIT]  = en_q[i];
          readdata_d[CTRL_DIR_BIT] = dir_q[i];
        end
        if (is_duty) readdata_d = 32'(duty_q[i]);
        if (is_eff)  readdata_d = 32'(eff[i]);
      end
    end
    if (addr == STATUS_ADDR) readdata_d = {31'b0, wd_trip_q};
  end

  assign readdata = readdata_q;

  for (genvar g = 0; g < NUM_MOTORS; g++) begin : g_ch
    gpio_nibble_t nib;

    motor_pwm_bank_pwm_channel #(
      .DUTY_W   (DUTY_W),
      .RAMP_STEP(RAMP_STEP)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .cnt_i      (cnt_q),
      .wrap_i     (wrap),
      .target_i   (duty_q[g]),
      .en_i       (en_q[g]),
      .dir_i      (dir_q[g]),
      .force_off_i(wd_trip_q),
      .eff_o      (eff[g]),
      .gpio_o     (nib)
    );

    assign GPIO_out[4*g +: 4] = nib;
  end

endmodule

// File: tb/tb_motor_pwm_bank.sv
// tb/tb_motor_pwm_bank.sv - self-checking bench for motor_pwm_bank (6 motors, 10-bit duty, step 4, watchdog 1000)
module tb_motor_pwm_bank;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        chipselect = 1'b0;
  logic        write = 1'b0;
  logic        read = 1'b0;
  logic [4:0]  addr = '0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [23:0] GPIO_out;

  motor_pwm_bank #(
    .NUM_MOTORS (6),
    .DUTY_W     (10),
    .RAMP_STEP  (4),
    .WDOG_CYCLES(1000)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .chipselect(chipselect),
    .write     (write),
    .read      (read),
    .addr      (addr),
    .writedata (writedata),
    .readdata  (readdata),
    .GPIO_out  (GPIO_out)
  );

  always #5 clk = ~clk;

  // Reference period phase and cycles since the last bus write.
  logic [9:0] tb_cnt;
  int         since_wr;
  always @(posedge clk) begin
    if (reset) tb_cnt <= '0;
    else       tb_cnt <= tb_cnt + 10'd1;
    if (reset || (chipselect && write)) since_wr <= 0;
    else                                since_wr <= since_wr + 1;
  end

  int passed = 0;
  int total  = 0;
  int pwm0_hi, in2_hi, both_hi;
  bit kick_en = 1'b1;

  typedef struct {
    bit          do_wr;
    logic [4:0]  a;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; write = 1'b1; read = 1'b0; addr = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; read = 1'b1; write = 1'b0; addr = a;
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0;
    d = readdata;
  endtask

  task automatic step();
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0; read = 1'b0;
    if (GPIO_out[3]) pwm0_hi++;
    if (GPIO_out[9]) in2_hi++;
    for (int m = 0; m < 6; m++) if (GPIO_out[4*m] && GPIO_out[4*m+1]) both_hi++;
    if (kick_en && since_wr >= 600) begin
      chipselect = 1'b1; write = 1'b1; addr = 5'd17; writedata = '0;
    end
  endtask

  task automatic wait_phase(input int p);
    bit found = 1'b0;
    for (int g = 0; g < 3000 && !found; g++) begin
      step();
      if (tb_cnt == 10'(p)) found = 1'b1;
    end
    chipselect = 1'b0; write = 1'b0;
    if (!found) check("wait_phase_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle(input int n);
    bit found = 1'b0;
    for (int g = 0; g < 3000 && !found; g++) begin
      @(negedge clk);
      if (since_wr == n) found = 1'b1;
    end
    if (!found) check("wait_idle_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    logic [31:0] rd;

    vecs[0]  = '{1'b1, 5'd8,  32'd100,        32'd100};
    vecs[1]  = '{1'b1, 5'd10, 32'd100,        32'd100};
    vecs[2]  = '{1'b1, 5'd0,  32'd1,          32'd1};
    vecs[3]  = '{1'b1, 5'd2,  32'd1,          32'd1};
    vecs[4]  = '{1'b1, 5'd9,  32'hFFFF_F123,  32'h123};
    vecs[5]  = '{1'b1, 5'd1,  32'hFFFF_FFFE,  32'd2};
    vecs[6]  = '{1'b1, 5'd6,  32'd3,          32'd0};
    vecs[7]  = '{1'b1, 5'd14, 32'd55,         32'd0};
    vecs[8]  = '{1'b0, 5'd30, 32'd0,          32'd0};
    vecs[9]  = '{1'b0, 5'd20, 32'd0,          32'd0};
    vecs[10] = '{1'b1, 5'd16, 32'd1,          32'd0};
    vecs[11] = '{1'b1, 5'd17, 32'd5,          32'd0};
    vecs[12] = '{1'b0, 5'd7,  32'd0,          32'd0};
    vecs[13] = '{1'b1, 5'd24, 32'd5,          32'd0};
    vecs[14] = '{1'b0, 5'd8,  32'd0,          32'd100};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset_gpio", 32'(GPIO_out), 32'd0);
    for (int a = 0; a < 32; a++) begin
      bus_read(5'(a), rd);
      check($sformatf("reset_read_%0d", a), rd, 32'd0);
    end

    for (int i = 0; i < 15; i++) begin
      if (vecs[i].do_wr) bus_write(vecs[i].a, vecs[i].wd);
      bus_read(vecs[i].a, rd);
      check($sformatf("vec%0d_addr%0d", i, vecs[i].a), rd, vecs[i].exp);
    end

    // Read latency: old data during the strobe cycle, new data one cycle later, then held.
    @(negedge clk);
    chipselect = 1'b1; read = 1'b1; addr = 5'd2;
    check("rd_before_edge", readdata, 32'd100);
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0; addr = 5'd8;
    check("rd_one_cycle", readdata, 32'd1);
    @(negedge clk);
    check("rd_hold", readdata, 32'd1);

    // Soft start of motor 0 towards 100, sampled mid-period.
    for (int k = 0; k <= 26; k++) begin
      wait_phase(512);
      bus_read(5'd24, rd);
      check($sformatf("ramp0_period%0d", k), rd, (4 * k < 100) ? 32'(4 * k) : 32'd100);
    end
    bus_read(5'd26, rd);
    check("ramp2_settled", rd, 32'd100);

    wait_phase(1023);
    pwm0_hi = 0;
    repeat (1024) step();
    check("pwm0_high_count", 32'(pwm0_hi), 32'd100);

    // Reverse motor 2 through zero.
    wait_phase(512);
    bus_write(5'd2, 32'd3);
    in2_hi = 0;
    both_hi = 0;
    for (int k = 1; k <= 27; k++) begin
      wait_phase(512);
      bus_read(5'd26, rd);
      check($sformatf("rev2_period%0d", k), rd, (k <= 25) ? 32'(100 - 4 * k) : 32'(4 * (k - 25)));
      if (k == 25) check("rev2_no_in2_before_flip", 32'(in2_hi), 32'd0);
    end
    check("rev2_in2_pulses", 32'(in2_hi > 0), 32'd1);
    check("in1_in2_exclusive", 32'(both_hi), 32'd0);

    // Disable motor 1 mid-ramp while its pwm is high.
    bus_write(5'd1, 32'd1);
    repeat (3) wait_phase(512);
    bus_read(5'd25, rd);
    check("ramp1_eff", rd, 32'd12);
    wait_phase(2);
    check("m1_nibble_active", 32'(GPIO_out[7:4]), 32'hD);
    chipselect = 1'b1; write = 1'b1; addr = 5'd1; writedata = 32'd0;
    @(negedge clk);
    check("m1_nibble_off_next", 32'(GPIO_out[7:4]), 32'h0);
    chipselect = 1'b0; write = 1'b0;
    bus_read(5'd25, rd);
    check("m1_eff_cleared", rd, 32'd0);

    // Watchdog: write landing on the expiry edge suppresses the trip.
    kick_en = 1'b0;
    bus_write(5'd17, 32'd0);
    wait_idle(999);
    chipselect = 1'b1; write = 1'b1; addr = 5'd17;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0;
    bus_read(5'd16, rd);
    check("wd_expiry_write_no_trip", rd, 32'd0);

    wait_idle(999);
    check("gpio_live_before_trip", 32'(GPIO_out != 0), 32'd1);
    chipselect = 1'b1; read = 1'b1; addr = 5'd16;
    @(negedge clk);
    check("wd_status_at_999", readdata, 32'd0);
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0;
    check("wd_status_at_1000", readdata, 32'd1);
    check("wd_gpio_off", 32'(GPIO_out), 32'd0);
    bus_write(5'd8, 32'd50);
    bus_read(5'd8, rd);
    check("wd_duty_write_ignored", rd, 32'd0);
    bus_read(5'd0, rd);
    check("wd_ctrl_forced", rd, 32'd0);
    bus_read(5'd24, rd);
    check("wd_eff_forced", rd, 32'd0);
    bus_write(5'd17, 32'd0);
    bus_read(5'd16, rd);
    check("kick_clears_trip", rd, 32'd0);
    bus_write(5'd8, 32'd50);
    bus_read(5'd8, rd);
    check("duty_write_after_kick", rd, 32'd50);

    // Reset mid-operation leaves no partial state.
    bus_write(5'd0, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("reset2_gpio", 32'(GPIO_out), 32'd0);
    bus_read(5'd8, rd);
    check("reset2_duty", rd, 32'd0);
    bus_read(5'd0, rd);
    check("reset2_ctrl", rd, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
